// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core memory-side blocks.
// Latency: n/a (types only).
// Backpressure: n/a.
package hsv_core_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } mem_tracker_state_t;

endpackage

// File: rtl/hsv_core_mem_tracker_if.sv
// Bundle between the mem pipeline (master) and the tracker (slave).
// Latency: n/a (wires only).
// Backpressure: permission flags can_issue_read/can_issue_write gate new issues.
interface hsv_core_mem_tracker_if #(
  parameter int CNT_W = 4
);
  logic             flush_req;
  logic             flush;
  logic             flush_ack;
  logic             read_issue;
  logic             read_done;
  logic             write_issue;
  logic             write_done;
  logic             write_pass;
  logic             write_launch;
  logic             can_issue_read;
  logic             can_issue_write;
  logic [CNT_W-1:0] pending_reads;
  logic [CNT_W-1:0] pending_writes;
  logic [CNT_W-1:0] write_balance;
  logic             protocol_err;
  logic             timeout_err;

  modport master (
    output flush_req, read_issue, read_done, write_issue, write_done,
           write_pass, write_launch,
    input  flush, flush_ack, can_issue_read, can_issue_write,
           pending_reads, pending_writes, write_balance, protocol_err, timeout_err
  );

  modport slave (
    input  flush_req, read_issue, read_done, write_issue, write_done,
           write_pass, write_launch,
    output flush, flush_ack, can_issue_read, can_issue_write,
           pending_reads, pending_writes, write_balance, protocol_err, timeout_err
  );
endinterface

// File: rtl/hsv_core_mem_sat_counter.sv
// Up/down counter that saturates at its limits and flags the offending step.
// Latency: count updates 1 cycle after up/dn; err is combinational for this cycle.
// Backpressure: none; clr has priority and discards up/dn.
module hsv_core_mem_sat_counter #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0,
  parameter int MAX    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] cnt,
  output logic             err
);

  // Signed mode uses the two's-complement range; unsigned runs 0..MAX.
  localparam logic [WIDTH-1:0] HI = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LO = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  logic inc;
  logic dec;

  // Simultaneous up and down cancel out and are never an error.
  assign inc = up & ~dn & ~clr;
  assign dec = dn & ~up & ~clr;
  assign err = (inc & (cnt == HI)) | (dec & (cnt == LO));

  // Count register: clear wins, steps past a limit are held at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != HI)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && (cnt != LO)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hsv_core_mem_tracker.sv
// Tracks outstanding reads/writes, gates issue and sequences drain->flush->ack.
// Latency: flush 1 cycle after drain condition, flush_ack 1 cycle after flush.
// Backpressure: issue permission drops while draining/flushing or at the limit.
// Optional watchdog enabled by defining HSV_CORE_MEM_TRACKER_TIMEOUT_EN.
module hsv_core_mem_tracker
  import hsv_core_pkg::*;
#(
  parameter int CNT_W          = 4,
  parameter int MAX_READS      = 8,
  parameter int MAX_WRITES     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk_core,
  input logic                  rst_core_n,
  hsv_core_mem_tracker_if.slave bus
);

  if ((MAX_READS > (1 << CNT_W) - 1) || (MAX_WRITES > (1 << CNT_W) - 1) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("hsv_core_mem_tracker: parameter out of range");
  end

  mem_tracker_state_t state;
  mem_tracker_state_t state_nxt;

  logic in_flush;
  logic any_evt;
  logic drained;
  logic rd_err;
  logic wr_err;
  logic bal_err;
  logic perm_err;

  assign in_flush = (state == FLUSH);
  assign any_evt  = bus.read_issue | bus.read_done | bus.write_issue |
                    bus.write_done | bus.write_pass | bus.write_launch;
  assign drained  = (bus.pending_reads == '0) & (bus.pending_writes == '0) &
                    (bus.write_balance == '0) & ~any_evt;

  // Reads and writes are mutually exclusive on the bus; each waits for the other to empty.
  assign bus.can_issue_read  = (state == RUN) & ~bus.flush_req &
                               (bus.pending_writes == '0) &
                               (bus.pending_reads < CNT_W'(MAX_READS));
  assign bus.can_issue_write = (state == RUN) & ~bus.flush_req &
                               (bus.pending_reads == '0) &
                               (bus.pending_writes < CNT_W'(MAX_WRITES));

  // Counter inputs are dropped during FLUSH, which also clears every counter.
  hsv_core_mem_sat_counter #(.WIDTH(CNT_W), .SIGNED(1'b0), .MAX(MAX_READS)) u_rd_cnt (
    .clk(clk_core), .rst_n(rst_core_n), .clr(in_flush),
    .up(bus.read_issue), .dn(bus.read_done), .cnt(bus.pending_reads), .err(rd_err)
  );

  hsv_core_mem_sat_counter #(.WIDTH(CNT_W), .SIGNED(1'b0), .MAX(MAX_WRITES)) u_wr_cnt (
    .clk(clk_core), .rst_n(rst_core_n), .clr(in_flush),
    .up(bus.write_issue), .dn(bus.write_done), .cnt(bus.pending_writes), .err(wr_err)
  );

  hsv_core_mem_sat_counter #(.WIDTH(CNT_W), .SIGNED(1'b1), .MAX((1 << (CNT_W-1)) - 1)) u_bal_cnt (
    .clk(clk_core), .rst_n(rst_core_n), .clr(in_flush),
    .up(bus.write_pass), .dn(bus.write_launch), .cnt(bus.write_balance), .err(bal_err)
  );

  assign perm_err = ~in_flush & ((bus.read_issue & ~bus.can_issue_read) |
                                 (bus.write_issue & ~bus.can_issue_write));

  // State register; reset parks in ACK so the pipeline sees a completed flush.
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) state <= ACK;
    else             state <= state_nxt;
  end

  // Next-state: drain until idle, pulse flush once, hold ack until request drops.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush_req) state_nxt = DRAIN;
      DRAIN:   if (!bus.flush_req) state_nxt = RUN;
               else if (drained)   state_nxt = FLUSH;
      FLUSH:   state_nxt = ACK;
      ACK:     if (!bus.flush_req) state_nxt = RUN;
      default: state_nxt = ACK;
    endcase
  end

  // Outputs: flush is also forced while reset is held so the pipeline clears too.
  always_comb begin
    bus.flush     = (state == FLUSH) | ~rst_core_n;
    bus.flush_ack = (state == ACK);
  end

  // Sticky misuse flag: survives flushes, only reset clears it.
  always_ff @(posedge clk_core) begin
    if (!rst_core_n)                             bus.protocol_err <= 1'b0;
    else if (rd_err | wr_err | bal_err | perm_err) bus.protocol_err <= 1'b1;
  end

`ifdef HSV_CORE_MEM_TRACKER_TIMEOUT_EN
  localparam int               WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run = ((bus.pending_reads | bus.pending_writes) != '0) &
                  ~bus.read_done & ~bus.write_done;

  // Watchdog: counts stalled cycles, saturates at the limit; a flush clears the error.
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      wd_cnt          <= '0;
      bus.timeout_err <= 1'b0;
    end else if (in_flush) begin
      wd_cnt          <= '0;
      bus.timeout_err <= 1'b0;
    end else if (!wd_run) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_MAX - 1'b1) bus.timeout_err <= 1'b1;
    end
  end
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hsv_core_mem_tracker.sv
// Directed bench for hsv_core_mem_tracker with hand-computed expectations.
// Latency: inputs driven 1 ns after posedge, outputs sampled at that point.
// Backpressure: exercised through can_issue_* and the saturation limits.
module tb_hsv_core_mem_tracker;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

`ifdef HSV_CORE_MEM_TRACKER_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  hsv_core_mem_tracker_if #(.CNT_W(4)) mif ();

  hsv_core_mem_tracker #(
    .CNT_W(4), .MAX_READS(8), .MAX_WRITES(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_core  (clk),
    .rst_core_n(rst_n),
    .bus       (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mif.flush_req    = 1'b0;
    mif.read_issue   = 1'b0;
    mif.read_done    = 1'b0;
    mif.write_issue  = 1'b0;
    mif.write_done   = 1'b0;
    mif.write_pass   = 1'b0;
    mif.write_launch = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst_n = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_flush", 32'(mif.flush), 32'd1);
    chk("rst_ack", 32'(mif.flush_ack), 32'd1);
    chk("rst_pr", 32'(mif.pending_reads), 32'd0);
    chk("rst_pw", 32'(mif.pending_writes), 32'd0);
    chk("rst_perr", 32'(mif.protocol_err), 32'd0);
    chk("rst_terr", 32'(mif.timeout_err), 32'd0);

    // release: cycle 1 still in ACK, cycle 2 in RUN
    rst_n = 1'b1;
    #1;
    chk("rel1_flush", 32'(mif.flush), 32'd0);
    chk("rel1_ack", 32'(mif.flush_ack), 32'd1);
    tick();
    chk("rel2_ack", 32'(mif.flush_ack), 32'd0);
    chk("rel2_cir", 32'(mif.can_issue_read), 32'd1);
    chk("rel2_ciw", 32'(mif.can_issue_write), 32'd1);

    // three reads, then issue+done together
    mif.read_issue = 1'b1;
    repeat (3) tick();
    chk("rd3", 32'(mif.pending_reads), 32'd3);
    mif.read_done = 1'b1;
    tick();
    chk("rd_simul", 32'(mif.pending_reads), 32'd3);
    mif.read_issue = 1'b0;
    mif.read_done  = 1'b0;
    #1;
    chk("ciw_blocked", 32'(mif.can_issue_write), 32'd0);
    mif.read_done = 1'b1;
    repeat (3) tick();
    mif.read_done = 1'b0;
    #1;
    chk("rd_empty", 32'(mif.pending_reads), 32'd0);
    chk("ciw_open", 32'(mif.can_issue_write), 32'd1);
    chk("perr_clean", 32'(mif.protocol_err), 32'd0);

    // fill to MAX_READS, then one too many
    mif.read_issue = 1'b1;
    repeat (8) tick();
    mif.read_issue = 1'b0;
    #1;
    chk("rd8", 32'(mif.pending_reads), 32'd8);
    chk("cir_full", 32'(mif.can_issue_read), 32'd0);
    chk("perr_at8", 32'(mif.protocol_err), 32'd0);
    mif.read_issue = 1'b1;
    tick();
    mif.read_issue = 1'b0;
    #1;
    chk("rd9_sat", 32'(mif.pending_reads), 32'd8);
    chk("rd9_perr", 32'(mif.protocol_err), 32'd1);

    // reset again to clear the sticky error
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst_perr", 32'(mif.protocol_err), 32'd0);
    chk("rerst_pr", 32'(mif.pending_reads), 32'd0);

    // signed write balance
    mif.write_launch = 1'b1;
    repeat (2) tick();
    mif.write_launch = 1'b0;
    #1;
    chk("bal_m2", 32'(mif.write_balance), 32'hE);
    mif.write_pass = 1'b1;
    repeat (2) tick();
    mif.write_pass = 1'b0;
    #1;
    chk("bal_0", 32'(mif.write_balance), 32'h0);

    // flush with two writes outstanding
    mif.write_issue = 1'b1;
    repeat (2) tick();
    mif.write_issue = 1'b0;
    #1;
    chk("wr2", 32'(mif.pending_writes), 32'd2);
    mif.flush_req = 1'b1;
    tick();
    chk("drain_flush", 32'(mif.flush), 32'd0);
    chk("drain_cir", 32'(mif.can_issue_read), 32'd0);
    tick();
    chk("drain_wait", 32'(mif.flush), 32'd0);
    mif.write_done = 1'b1;
    repeat (2) tick();
    mif.write_done = 1'b0;
    #1;
    chk("drain_pw0", 32'(mif.pending_writes), 32'd0);
    chk("drain_noflush", 32'(mif.flush), 32'd0);
    tick();
    chk("fl_pulse", 32'(mif.flush), 32'd1);
    chk("fl_noack", 32'(mif.flush_ack), 32'd0);
    mif.read_issue = 1'b1;
    tick();
    mif.read_issue = 1'b0;
    #1;
    chk("ack_flush", 32'(mif.flush), 32'd0);
    chk("ack_rise", 32'(mif.flush_ack), 32'd1);
    chk("fl_ignored", 32'(mif.pending_reads), 32'd0);
    chk("fl_perr", 32'(mif.protocol_err), 32'd0);
    tick();
    chk("ack_hold", 32'(mif.flush_ack), 32'd1);
    mif.flush_req = 1'b0;
    tick();
    chk("ack_drop", 32'(mif.flush_ack), 32'd0);
    chk("ack_run", 32'(mif.can_issue_read), 32'd1);

    // abandoned drain returns to RUN without a flush
    mif.read_issue = 1'b1;
    tick();
    mif.read_issue = 1'b0;
    mif.flush_req  = 1'b1;
    tick();
    chk("abort_drain", 32'(mif.can_issue_read), 32'd0);
    mif.flush_req = 1'b0;
    tick();
    chk("abort_flush", 32'(mif.flush), 32'd0);
    chk("abort_ack", 32'(mif.flush_ack), 32'd0);
    chk("abort_run", 32'(mif.can_issue_read), 32'd1);
    mif.read_done = 1'b1;
    tick();
    mif.read_done = 1'b0;

    // stalled read: watchdog fires after 16 stalled cycles when enabled
    mif.read_issue = 1'b1;
    tick();
    mif.read_issue = 1'b0;
    repeat (15) tick();
    chk("to_early", 32'(mif.timeout_err), 32'd0);
    tick();
    chk("to_fire", 32'(mif.timeout_err), 32'(EXP_TO));
    mif.read_done = 1'b1;
    tick();
    mif.read_done = 1'b0;
    mif.flush_req = 1'b1;
    repeat (2) tick();
    chk("to_flush", 32'(mif.flush), 32'd1);
    tick();
    chk("to_clear", 32'(mif.timeout_err), 32'd0);
    mif.flush_req = 1'b0;
    tick();

    // reset in the middle of a drain
    mif.write_issue = 1'b1;
    tick();
    mif.write_issue = 1'b0;
    mif.flush_req   = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_flush", 32'(mif.flush), 32'd1);
    chk("mid_ack", 32'(mif.flush_ack), 32'd1);
    chk("mid_pw", 32'(mif.pending_writes), 32'd0);
    rst_n         = 1'b1;
    mif.flush_req = 1'b0;
    #1;
    chk("mid_rel", 32'(mif.flush), 32'd0);
    tick();
    chk("mid_run", 32'(mif.flush_ack), 32'd0);

    // balance underflow saturates at -8
    mif.write_launch = 1'b1;
    repeat (8) tick();
    mif.write_launch = 1'b0;
    #1;
    chk("bal_m8", 32'(mif.write_balance), 32'h8);
    chk("bal_m8_perr", 32'(mif.protocol_err), 32'd0);
    mif.write_launch = 1'b1;
    tick();
    mif.write_launch = 1'b0;
    #1;
    chk("bal_sat", 32'(mif.write_balance), 32'h8);
    chk("bal_sat_perr", 32'(mif.protocol_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
